mdu_ctrl: RTL and testbench

Multiply/divide unit controller with HI/LO registers for the 5-stage MIPS pipeline. It sits beside the ALU in the E stage.
- Accepts MULT/MULTU/DIV/DIVU starts and MTHI/MTLO writes.
- Sequences the multi-cycle operation with a busy counter and supplies HI/LO to MFHI/MFLO.
- Raises the stall request that the hazard unit ORs into the D-stage stall.

---
 rtl/mdu_ctrl_pkg.sv | 27 ++
 rtl/mdu_ctrl_md_calc.sv | 67 ++++++
 rtl/mdu_ctrl.sv | 98 +++++++++
 tb/tb_mdu_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - mdop encodings, FSM states and decode helpers for the MD unit
package mdu_ctrl_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_MFHI  = 3'd6;
    localparam logic [2:0] MD_MFLO  = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // True for the four ops that occupy the unit for several cycles
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_md_calc.sv
// rtl/mdu_ctrl_md_calc.sv - combinational 64-bit multiply/divide result generator
module mdu_ctrl_md_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        sgn_div;

    // Signed product via sign extension; the low 64 bits of the wide product are exact
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'b0, a} * {32'b0, b};

    // One shared unsigned divider: signed divide works on magnitudes and fixes signs after
    assign sgn_div = (mdop == MD_DIV);
    assign mag_a   = a[31] ? (~a + 32'd1) : a;
    assign mag_b   = b[31] ? (~b + 32'd1) : b;
    assign dvd     = sgn_div ? mag_a : a;
    assign dvs     = sgn_div ? mag_b : b;
    assign quo     = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
    assign rem     = (dvs == 32'd0) ? 32'd0 : dvd % dvs;

    // Select the result for the requested op; quotient truncates toward zero, remainder follows dividend
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        div0   = 1'b0;
        case (mdop)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                div0   = (b == 32'd0);
                res_lo = (a[31] ^ b[31]) ? (~quo + 32'd1) : quo;
                res_hi = a[31] ? (~rem + 32'd1) : rem;
            end
            MD_DIVU: begin
                div0   = (b == 32'd0);
                res_lo = quo;
                res_hi = rem;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide controller with HI/LO registers and D-stage stall request
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_is_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    localparam logic [3:0] MULT_LAST = 4'(MULT_CYC - 1);
    localparam logic [3:0] DIV_LAST  = 4'(DIV_CYC - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_div0;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div0;
    logic        op_md;

    mdu_ctrl_md_calc u_calc (
        .mdop   (mdop),
        .a      (a),
        .b      (b),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    assign op_md = is_muldiv(mdop);

    // Stall the D-stage MD op while busy, and already in the cycle a mult/div is launched
    assign md_stall = d_is_md & (busy | (start & op_md));

    // Sequencer: latch result at start, count down while busy, commit HI/LO on the last cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            busy      <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_div0 <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (op_md) begin
                            pend_hi   <= res_hi;
                            pend_lo   <= res_lo;
                            pend_div0 <= div0;
                            cnt       <= is_mult(mdop) ? MULT_LAST : DIV_LAST;
                            busy      <= 1'b1;
                            state     <= ST_RUN;
                        end else if (mdop == MD_MTHI) begin
                            hi <= a;
                        end else if (mdop == MD_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                ST_RUN: begin
                    // A start arriving here is a protocol violation and is ignored
                    if (cnt == 4'd0) begin
                        if (!pend_div0) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard bench for mdu_ctrl against an arithmetic reference model
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mdop = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        d_is_md = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_stall;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mdop     (mdop),
        .a        (a),
        .b        (b),
        .d_is_md  (d_is_md),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .md_stall (md_stall)
    );

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    int          cyc = 0;
    int          bs = 1;
    int          be = 0;
    int          dmode = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // d_is_md pattern: 0 = never, 1 = always, otherwise random per cycle
    always @(posedge clk) begin
        #1;
        case (dmode)
            0:       d_is_md = 1'b0;
            1:       d_is_md = 1'b1;
            default: d_is_md = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h required %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what HI/LO hold once the op has completed, and how long busy lasts
    function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] oh, input logic [31:0] ol,
                                  output logic [31:0] nh, output logic [31:0] nl, output int n);
        longint sx, sy, sp, sq, sr;
        longint unsigned ux, uy, up, uq, ur;
        nh = oh;
        nl = ol;
        n  = 0;
        case (op)
            MD_MULT: begin
                sx = $signed(x); sy = $signed(y); sp = sx * sy;
                nh = sp[63:32]; nl = sp[31:0]; n = MULT_CYC;
            end
            MD_MULTU: begin
                ux = x; uy = y; up = ux * uy;
                nh = up[63:32]; nl = up[31:0]; n = MULT_CYC;
            end
            MD_DIV: begin
                n = DIV_CYC;
                if (y != 0) begin
                    sx = $signed(x); sy = $signed(y); sq = sx / sy; sr = sx % sy;
                    nl = sq[31:0]; nh = sr[31:0];
                end
            end
            MD_DIVU: begin
                n = DIV_CYC;
                if (y != 0) begin
                    ux = x; uy = y; uq = ux / uy; ur = ux % uy;
                    nl = uq[31:0]; nh = ur[31:0];
                end
            end
            MD_MTHI: nh = x;
            MD_MTLO: nl = x;
            default: ;
        endcase
    endfunction

    // Monitor: busy/md_stall every cycle, HI/LO whenever a queued result falls due
    always @(negedge clk) begin : mon
        logic eb;
        exp_t e;
        if (cyc >= 1) begin
            eb = (cyc >= bs) && (cyc <= be);
            chk("busy", 32'(busy), 32'(eb));
            chk("md_stall", 32'(md_stall), 32'(d_is_md && (eb || (start && mdop <= MD_DIVU))));
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                if (e.due < cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: result missed, due cycle %0d now %0d", e.tag, e.due, cyc);
                end else begin
                    chk({e.tag, " hi"}, hi, e.hi);
                    chk({e.tag, " lo"}, lo, e.lo);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [31:0] nh, nl;
        int n, t;
        while (cyc <= be) step();
        t = cyc;
        model(op, x, y, m_hi, m_lo, nh, nl, n);
        start = 1'b1; mdop = op; a = x; b = y;
        if (n > 0) begin
            bs = t + 1;
            be = t + n;
            sbq.push_back('{t + n + 1, nh, nl, tag});
        end else begin
            sbq.push_back('{t + 1, nh, nl, tag});
        end
        m_hi = nh;
        m_lo = nl;
        step();
        start = 1'b0; mdop = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin : drv
        int t;
        sbq.push_back('{1, 32'd0, 32'd0, "reset"});
        step();
        step();
        reset = 1'b0;

        dmode = 1;
        step();
        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2, "mult");
        dmode = 0;
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div");
        issue(MD_DIVU, 32'd7, 32'd2, "divu");
        issue(MD_DIVU, 32'd5, 32'd0, "divu0");
        issue(MD_DIV, 32'h8000_0000, 32'd0, "div0");
        issue(MD_MTHI, 32'h1234_5678, 32'd0, "mthi");
        issue(MD_MTLO, 32'h9ABC_DEF0, 32'd0, "mtlo");
        issue(MD_MFHI, 32'h5555_5555, 32'd0, "mfhi");
        dmode = 2;

        issue(MD_DIV, 32'd100, 32'd7, "div_busy");
        step();
        $display("note: driving start while busy (protocol violation), it must be ignored");
        start = 1'b1; mdop = MD_MTHI; a = 32'hDEAD_BEEF;
        step();
        mdop = MD_MULT; a = 32'h0000_0003; b = 32'h0000_0003;
        step();
        start = 1'b0;

        while (cyc <= be) step();
        t = cyc;
        start = 1'b1; mdop = MD_DIV; a = 32'd1000; b = 32'd3;
        bs = t + 1;
        be = t + DIV_CYC;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        be = t + 3;
        m_hi = 32'd0;
        m_lo = 32'd0;
        sbq.push_back('{t + 4, 32'd0, 32'd0, "reset_mid"});
        sbq.push_back('{t + 4 + DIV_CYC, 32'd0, 32'd0, "reset_no_late"});
        step();
        reset = 1'b0;
        repeat (DIV_CYC + 2) step();

        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) step();
            issue(3'($urandom_range(0, 7)), pick(), pick(), $sformatf("rnd%0d", i));
        end

        for (int k = 0; k < 40 && sbq.size() > 0; k++) step();
        while (sbq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: result never checked (due cycle %0d)", sbq[0].tag, sbq[0].due);
            void'(sbq.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #600000;
        n_bad++;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
